alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 159 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Single-entry registered ALU execute stage with valid/ready handshaking on
// both sides. An operation accepted on a clock edge produces its result,
// zero flag and out_valid right after that edge (one cycle of latency). The
// stage keeps full throughput: a new operation can be accepted in the same
// cycle that the held result is taken downstream.
//
// Optional feature:
//   ALU_OVF_EN  - when defined, adds output ovf, a registered signed-overflow
//                 flag for add (0011) and subtract (0100).
//
// Ports:
//   clk        in   1   clock, all state updates on its rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   upstream operation valid
//   in_ready   out  1   stage accepts an operation this cycle
//   alu_sel    in   4   operation select
//   op_a       in   32  rs operand
//   op_b       in   32  rt operand
//   shamt      in   5   shift amount
//   flush      in   1   drop the held result and refuse input this cycle
//   out_valid  out  1   result/zero (and ovf) are valid
//   out_ready  in   1   downstream accepts the result
//   result     out  32  registered ALU result
//   zero       out  1   registered flag, high when result == 0
//   ovf        out  1   registered signed overflow (ALU_OVF_EN only)
//   op_count   out  16  accepted-operation counter, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        shamt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
`ifdef ALU_OVF_EN
    output logic              ovf,
`endif
    output logic [15:0]       op_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;

    // Unassigned select codes fall through to zero, which also makes the
    // zero flag come out high for them.
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [3:0]        sel,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [4:0]        sh
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        r;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        case (sel)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_SLT: r = (sa < sb) ? DATA_W'(1) : '0;
            OP_SLL: r = b << sh;
            OP_SRL: r = b >> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_OVF_EN
    // Two's-complement overflow judged from operand and result sign bits.
    function automatic logic ovf_calc(
        input logic [3:0]        sel,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] r
    );
        logic o;
        o = 1'b0;
        case (sel)
            OP_ADD: o = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            OP_SUB: o = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            default: o = 1'b0;
        endcase
        return o;
    endfunction
`endif

    logic              vld_p0;
    logic [DATA_W-1:0] result_p0;
    logic              zero_p0;
    logic [15:0]       op_count_p0;
    logic              take;
    logic [DATA_W-1:0] alu_res;

`ifdef ALU_OVF_EN
    logic              ovf_p0;
`endif

    // Ready whenever the register is empty or being drained this cycle;
    // reset and flush both close the input side.
    assign in_ready = !rst && !flush && (!vld_p0 || out_ready);
    assign take     = in_valid && in_ready;
    assign alu_res  = alu_calc(alu_sel, op_a, op_b, shamt);

    // ---- stage p0: result register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            result_p0   <= '0;
            zero_p0     <= 1'b1;
            op_count_p0 <= '0;
`ifdef ALU_OVF_EN
            ovf_p0      <= 1'b0;
`endif
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (take) begin
            vld_p0      <= 1'b1;
            result_p0   <= alu_res;
            zero_p0     <= (alu_res == '0);
            op_count_p0 <= op_count_p0 + 16'd1;
`ifdef ALU_OVF_EN
            ovf_p0      <= ovf_calc(alu_sel, op_a, op_b, alu_res);
`endif
        end else if (vld_p0 && out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign result    = result_p0;
    assign zero      = zero_p0;
    assign op_count  = op_count_p0;
`ifdef ALU_OVF_EN
    assign ovf       = ovf_p0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [15:0] op_count;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .op_count  (op_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the outputs should be after the next edge.
    logic        m_v   = 1'b0;
    logic [31:0] m_res = 32'h0;
    logic        m_z   = 1'b1;
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation semantics written directly from the instruction table.
    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (s)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a ^ b;
            4'd3: return 32'(a + b);
            4'd4: return 32'(a - b);
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            4'd8: return b << sh;
            4'd9: return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Overflow: exact result falls outside the 32-bit signed range.
    function automatic logic ref_ovf(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, x;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s == 4'd3)      x = sa + sb;
        else if (s == 4'd4) x = sa - sb;
        else return 1'b0;
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // One clock: check in_ready before the edge, advance the model, then
    // check every output just after the edge.
    task automatic tick(input bit chk_en);
        logic exp_ir;
        #1;
        exp_ir = !rst && !flush && (!m_v || out_ready);
        if (chk_en) check("in_ready", 32'(in_ready), 32'(exp_ir));
        if (rst) begin
            m_v = 1'b0; m_res = 32'h0; m_z = 1'b1; m_ovf = 1'b0; m_cnt = 16'h0;
        end else if (flush) begin
            m_v = 1'b0;
        end else if (in_valid && exp_ir) begin
            m_v   = 1'b1;
            m_res = ref_alu(alu_sel, op_a, op_b, shamt);
            m_z   = (m_res == 32'h0);
            m_ovf = ref_ovf(alu_sel, op_a, op_b);
            m_cnt = m_cnt + 16'd1;
        end else if (m_v && out_ready) begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_v));
            check("result", result, m_res);
            check("zero", 32'(zero), 32'(m_z));
            check("op_count", 32'(op_count), 32'(m_cnt));
`ifdef ALU_OVF_EN
            check("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    endtask

    task automatic set_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        alu_sel = s; op_a = a; op_b = b; shamt = sh;
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{4'b0011, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1'b0});
        vecs.push_back('{4'b0100, 32'h1234,     32'h1234,     5'd0,  32'h0,        1'b1, 1'b0});
        vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0});
        vecs.push_back('{4'b0111, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b1, 1'b0});
        vecs.push_back('{4'b0111, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'd1,        1'b0, 1'b0});
        vecs.push_back('{4'b1000, 32'h0,        32'd1,        5'd31, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{4'b1001, 32'h0,        32'h80000000, 5'd31, 32'd1,        1'b0, 1'b0});
        vecs.push_back('{4'b1001, 32'h0,        32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0});
        vecs.push_back('{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0});
        vecs.push_back('{4'b0011, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{4'b0100, 32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{4'b0100, 32'h0,        32'd1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{4'b0011, 32'h80000000, 32'h80000000, 5'd0,  32'h0,        1'b1, 1'b1});
        vecs.push_back('{4'b0101, 32'd3,        32'd4,        5'd0,  32'h0,        1'b1, 1'b0});
        vecs.push_back('{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h0,        1'b1, 1'b0});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0);

        // Reset state
        tick(1);
        tick(1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // First operation after reset, one cycle latency
        in_valid = 1'b1;
        set_op(4'b0011, 32'd5, 32'd7, 5'd0);
        tick(1);
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_result", result, 32'd12);
        check("first_zero", 32'(zero), 32'd0);
        check("first_op_count", 32'(op_count), 32'd1);

        // Table vectors, back to back
        foreach (vecs[i]) begin
            set_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sh);
            tick(1);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
`ifdef ALU_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
        end

        // Backpressure: hold 12 for three cycles, then take a new op with no bubble
        set_op(4'b0011, 32'd5, 32'd7, 5'd0);
        tick(1);
        out_ready = 1'b0;
        set_op(4'b0100, 32'd9, 32'd4, 5'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("stall_result", result, 32'd12);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick(1);
        check("release_result", result, 32'd5);
        check("release_out_valid", 32'(out_valid), 32'd1);

        // Drain with no new input
        in_valid = 1'b0;
        tick(1);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Flush while holding a result and offering new input
        in_valid = 1'b1;
        set_op(4'b0001, 32'd1, 32'd2, 5'd0);
        tick(1);
        out_ready = 1'b0;
        flush = 1'b1;
        begin
            logic [15:0] cnt_before;
            cnt_before = op_count;
            #1;
            check("flush_in_ready", 32'(in_ready), 32'd0);
            tick(1);
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_op_count", 32'(op_count), 32'(cnt_before));
        end
        flush = 1'b0;

        // Reset in the middle of a stall
        tick(1);
        tick(1);
        check("prestall_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] s;
            logic [31:0] a, b;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: s = 4'($urandom_range(0, 4));
                3: s = 4'd7;
                4: s = 4'd8;
                5: s = 4'd9;
                6: s = 4'($urandom_range(0, 15));
                default: s = 4'($urandom_range(0, 9));
            endcase
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'h7FFFFFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h80000000;
            if ($urandom_range(0, 9) == 0) b = a;
            set_op(s, a, b, 5'($urandom_range(0, 31)));
            tick(1);
        end

        // op_count wrap
        rst = 1'b1; flush = 1'b0;
        tick(1);
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        set_op(4'b0011, 32'd1, 32'd1, 5'd0);
        for (int n = 0; n < 65535; n++) tick(0);
        #1;
        check("wrap_pre_count", 32'(op_count), 32'h0000FFFF);
        tick(1);
        check("wrap_count", 32'(op_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
